// File: rtl/dot11_ofdm_tx.sv
// dot11_ofdm_tx
// Simplified 802.11a legacy DATA-field transmitter, BPSK rate 1/2.
// The frame header word (BRAM word 0, bits [11:0] = PSDU length in bytes) is
// read first. The SERVICE/PSDU/tail/pad bit stream is then scrambled,
// convolutionally encoded (K=7, 133/171) and interleaved, one symbol at a time.
// Each symbol is streamed as 64 frequency-domain samples in FFT-bin order,
// with pilots, nulls and the per-bin mask applied.
//
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   phy_tx_start            : single-cycle start request (honoured only in IDLE)
//   phy_tx_started          : busy flag, start+1 .. done pulse
//   phy_tx_done             : one-cycle pulse after the last sample transfers
//   init_pilot_scram_state  : pilot scrambler seed
//   init_data_scram_state   : data scrambler seed
//   bram_addr / bram_din    : 64-bit BRAM read port, 1-cycle read latency
//   result_iq_valid/ready   : sample handshake toward the IFFT
//   result_i / result_q     : sample value (q is always zero)
//   mask                    : bit k (k<64) forces bin k to zero
module dot11_ofdm_tx #(
  parameter int AMP = 8192
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               phy_tx_start,
  output logic               phy_tx_started,
  output logic               phy_tx_done,
  input  logic [6:0]         init_pilot_scram_state,
  input  logic [6:0]         init_data_scram_state,
  input  logic [63:0]        bram_din,
  output logic [9:0]         bram_addr,
  input  logic               result_iq_ready,
  output logic               result_iq_valid,
  output logic signed [15:0] result_i,
  output logic signed [15:0] result_q,
  input  logic [127:0]       mask
);

  localparam logic signed [15:0] POS = 16'(AMP);
  localparam logic signed [15:0] NEG = 16'(-AMP);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_RUN, S_DONE} state_t;
  // Sub-phases of RUN: build one symbol bit by bit (stalling for BRAM word
  // fetches), then stream its 64 bins.
  typedef enum logic [1:0] {P_BIT, P_WAIT1, P_WAIT2, P_OUT} phase_t;

  state_t             state_q;
  phase_t             phase_q;
  logic               hdr_q;
  logic [15:0]        psdu_end_q;   // first bit index past the PSDU
  logic [15:0]        tail_end_q;   // first bit index past the tail
  logic [15:0]        bit_q;        // stream bit index
  logic [4:0]         j_q;          // bit index within current symbol
  logic [6:0]         dscr_q;
  logic [6:0]         pscr_q;
  logic [5:0]         hist_q;       // encoder history, [0] = newest
  logic [47:0]        ilv_q;        // interleaved coded bits of one symbol
  logic [63:0]        word_q;
  logic [9:0]         word_idx_q;   // BRAM word currently held in word_q
  logic [6:0]         bin_q;        // next bin to present; 64 = all presented
  logic               started_q;
  logic               done_q;
  logic               valid_q;
  logic signed [15:0] i_q;
  logic [9:0]         addr_q;

  logic               unused_mask_hi;
  assign unused_mask_hi = ^mask[127:64];

  // ---------------- bit source / scrambler / encoder ----------------
  logic [15:0] poff;
  logic        in_psdu, in_tail, need_fetch, in_bit, fb, sbit, enc_a, enc_b;
  logic [9:0]  need_word;
  logic [5:0]  pos_a, pos_b;

  function automatic logic [5:0] ilv_pos(input logic [5:0] k);
    return ({2'b00, k[3:0]} * 6'd3) + {4'b0000, k[5:4]};
  endfunction

  always_comb begin
    poff       = bit_q - 16'd16;
    in_psdu    = (bit_q >= 16'd16) && (bit_q < psdu_end_q);
    in_tail    = (bit_q >= psdu_end_q) && (bit_q < tail_end_q);
    need_word  = poff[15:6] + 10'd1;
    need_fetch = in_psdu && (need_word != word_idx_q);
    in_bit     = in_psdu ? word_q[poff[5:0]] : 1'b0;
    fb         = dscr_q[6] ^ dscr_q[3];
    sbit       = in_tail ? 1'b0 : (in_bit ^ fb);
    enc_a      = sbit ^ hist_q[1] ^ hist_q[2] ^ hist_q[4] ^ hist_q[5];
    enc_b      = sbit ^ hist_q[0] ^ hist_q[1] ^ hist_q[2] ^ hist_q[5];
    pos_a      = ilv_pos({j_q, 1'b0});
    pos_b      = ilv_pos({j_q, 1'b1});
  end

  // ---------------- bin value ----------------
  logic [5:0]         bin6;
  logic [5:0]         dat_idx;
  logic [63:0]        mask_lo;
  logic               pb;
  logic signed [15:0] samp;

  always_comb begin
    bin6    = bin_q[5:0];
    mask_lo = mask[63:0];
    pb      = pscr_q[6] ^ pscr_q[3];
    dat_idx = '0;
    samp    = '0;
    // Data index: ascending logical subcarrier -26..26 skipping 0, +-7, +-21
    if (bin6 >= 6'd38 && bin6 <= 6'd42)      dat_idx = bin6 - 6'd38;
    else if (bin6 >= 6'd44 && bin6 <= 6'd56) dat_idx = bin6 - 6'd39;
    else if (bin6 >= 6'd58)                  dat_idx = bin6 - 6'd40;
    else if (bin6 >= 6'd1 && bin6 <= 6'd6)   dat_idx = bin6 + 6'd23;
    else if (bin6 >= 6'd8 && bin6 <= 6'd20)  dat_idx = bin6 + 6'd22;
    else if (bin6 >= 6'd22 && bin6 <= 6'd26) dat_idx = bin6 + 6'd21;

    if (mask_lo[bin6] || bin6 == 6'd0 || (bin6 >= 6'd27 && bin6 <= 6'd37))
      samp = '0;
    else if (bin6 == 6'd7 || bin6 == 6'd43 || bin6 == 6'd57)
      samp = pb ? NEG : POS;
    else if (bin6 == 6'd21)
      samp = pb ? POS : NEG;
    else
      samp = ilv_q[dat_idx] ? POS : NEG;
  end

  // ---------------- control ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= P_BIT;
      hdr_q      <= 1'b0;
      psdu_end_q <= '0;
      tail_end_q <= '0;
      bit_q      <= '0;
      j_q        <= '0;
      dscr_q     <= '0;
      pscr_q     <= '0;
      hist_q     <= '0;
      ilv_q      <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      bin_q      <= '0;
      started_q  <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      i_q        <= '0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (phy_tx_start) begin
            state_q    <= S_HDR;
            phase_q    <= P_BIT;
            hdr_q      <= 1'b0;
            started_q  <= 1'b1;
            addr_q     <= '0;
            dscr_q     <= init_data_scram_state;
            pscr_q     <= init_pilot_scram_state;
            hist_q     <= '0;
            bit_q      <= '0;
            j_q        <= '0;
            word_idx_q <= '0;  // word 0 is the header, never a PSDU word
          end
        end
        S_HDR: begin
          // First cycle: address 0 is on the bus; second: data is valid.
          if (!hdr_q) begin
            hdr_q <= 1'b1;
          end else begin
            psdu_end_q <= 16'd16 + {1'b0, bram_din[11:0], 3'b000};
            tail_end_q <= 16'd22 + {1'b0, bram_din[11:0], 3'b000};
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          case (phase_q)
            P_BIT: begin
              if (need_fetch) begin
                addr_q  <= need_word;
                phase_q <= P_WAIT1;
              end else begin
                dscr_q       <= {dscr_q[5:0], fb};
                hist_q       <= {hist_q[4:0], sbit};
                ilv_q[pos_a] <= enc_a;
                ilv_q[pos_b] <= enc_b;
                bit_q        <= bit_q + 16'd1;
                if (j_q == 5'd23) begin
                  j_q     <= '0;
                  bin_q   <= '0;
                  phase_q <= P_OUT;
                end else begin
                  j_q <= j_q + 5'd1;
                end
              end
            end
            P_WAIT1: phase_q <= P_WAIT2;
            P_WAIT2: begin
              word_q     <= bram_din;
              word_idx_q <= addr_q;
              phase_q    <= P_BIT;
            end
            P_OUT: begin
              // Load a new sample only when the output register is free.
              if (!valid_q || result_iq_ready) begin
                if (!bin_q[6]) begin
                  valid_q <= 1'b1;
                  i_q     <= samp;
                  bin_q   <= bin_q + 7'd1;
                end else begin
                  valid_q <= 1'b0;
                  i_q     <= '0;
                  phase_q <= P_BIT;
                  pscr_q  <= {pscr_q[5:0], pb};
                  if (bit_q >= tail_end_q) begin
                    state_q   <= S_DONE;
                    done_q    <= 1'b1;
                    started_q <= 1'b0;
                  end
                end
              end
            end
            default: phase_q <= P_BIT;
          endcase
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign phy_tx_started  = started_q;
  assign phy_tx_done     = done_q;
  assign bram_addr       = addr_q;
  assign result_iq_valid = valid_q;
  assign result_i        = i_q;
  assign result_q        = '0;

endmodule

// File: tb/tb_dot11_ofdm_tx.sv
// Directed bench for dot11_ofdm_tx: a behavioural BRAM, a whole-frame
// reference model, and a linear sequence of frames with hand-derived checks.
module tb_dot11_ofdm_tx;
  localparam int AMP = 8192;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               phy_tx_start = 1'b0;
  logic               phy_tx_started, phy_tx_done;
  logic [6:0]         init_pilot_scram_state = '0;
  logic [6:0]         init_data_scram_state = '0;
  logic [63:0]        bram_din = '0;
  logic [9:0]         bram_addr;
  logic               result_iq_ready = 1'b1;
  logic               result_iq_valid;
  logic signed [15:0] result_i, result_q;
  logic [127:0]       mask = '0;

  dot11_ofdm_tx #(.AMP(AMP)) dut (
    .clock(clock), .reset(reset), .phy_tx_start(phy_tx_start),
    .phy_tx_started(phy_tx_started), .phy_tx_done(phy_tx_done),
    .init_pilot_scram_state(init_pilot_scram_state),
    .init_data_scram_state(init_data_scram_state),
    .bram_din(bram_din), .bram_addr(bram_addr),
    .result_iq_ready(result_iq_ready), .result_iq_valid(result_iq_valid),
    .result_i(result_i), .result_q(result_q), .mask(mask)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [0:1023];
  logic [7:0]  psdu [0:4095];
  always @(posedge clock) bram_din <= mem[bram_addr];

  int checks = 0;
  int errors = 0;
  int got[$];
  int expq[$];
  int refA[$];
  int done_cnt, hold_bad, first_valid, started_at_fv, started_at_done, q_nonzero;
  bit timed_out;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int len, input bit zero);
    for (int w = 0; w < 1024; w++) mem[w] = '0;
    mem[0] = 64'(len);
    for (int j = 0; j < len; j++) begin
      psdu[j] = zero ? 8'h00 : 8'($urandom);
      mem[1 + j / 8][8 * (j % 8) +: 8] = psdu[j];
    end
  endtask

  // Reference: build the whole bit stream, scramble, encode, then map symbols.
  task automatic build_model(input int len, input logic [6:0] dseed,
                             input logic [6:0] pseed, input logic [127:0] m);
    int nsym, nb, idx, pv;
    bit sb[];
    bit cd[];
    bit il[48];
    int e[64];
    logic [6:0] s, ps, d;
    bit x, f;
    nsym = (22 + 8 * len + 23) / 24;
    nb   = 24 * nsym;
    sb   = new[nb];
    cd   = new[2 * nb];
    s    = dseed;
    for (int b = 0; b < nb; b++) begin
      x = 1'b0;
      if (b >= 16 && b < 16 + 8 * len) x = psdu[(b - 16) / 8][(b - 16) % 8];
      f = s[6] ^ s[3];
      s = {s[5:0], f};
      sb[b] = (b >= 16 + 8 * len && b < 22 + 8 * len) ? 1'b0 : (x ^ f);
    end
    d = '0;
    for (int b = 0; b < nb; b++) begin
      d = {d[5:0], sb[b]};
      cd[2 * b]     = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      cd[2 * b + 1] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[6];
    end
    expq.delete();
    ps = pseed;
    for (int sy = 0; sy < nsym; sy++) begin
      for (int k = 0; k < 48; k++) il[3 * (k % 16) + k / 16] = cd[48 * sy + k];
      f  = ps[6] ^ ps[3];
      ps = {ps[5:0], f};
      pv = f ? -AMP : AMP;
      for (int b = 0; b < 64; b++) e[b] = 0;
      idx = 0;
      for (int c = -26; c <= 26; c++) begin
        if (c == 0 || c == 7 || c == -7 || c == 21 || c == -21) continue;
        e[c < 0 ? c + 64 : c] = il[idx] ? AMP : -AMP;
        idx++;
      end
      e[7] = pv; e[21] = -pv; e[43] = pv; e[57] = pv;
      for (int b = 0; b < 64; b++) expq.push_back(m[b] ? 0 : e[b]);
    end
  endtask

  task automatic run_frame(input logic [6:0] dseed, input logic [6:0] pseed,
                           input logic [127:0] m, input bit rnd_ready,
                           input int repulse_at);
    int cyc, post;
    bit prev_valid, prev_ready;
    logic signed [15:0] prev_i;
    got.delete();
    done_cnt = 0; hold_bad = 0; first_valid = -1; started_at_fv = 0;
    started_at_done = -1; q_nonzero = 0; timed_out = 0;
    prev_valid = 0; prev_ready = 0; prev_i = '0;
    cyc = 0; post = -1;
    @(negedge clock);
    mask = m;
    init_data_scram_state = dseed;
    init_pilot_scram_state = pseed;
    result_iq_ready = 1'b1;
    phy_tx_start = 1'b1;
    while (post != 0) begin
      @(negedge clock);
      cyc++;
      phy_tx_start = (cyc == repulse_at);
      if (prev_valid && !prev_ready && (!result_iq_valid || result_i != prev_i))
        hold_bad++;
      if (result_iq_valid && first_valid < 0) begin
        first_valid = cyc;
        started_at_fv = int'(phy_tx_started);
      end
      if (result_q != 0) q_nonzero++;
      result_iq_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (result_iq_valid && result_iq_ready) got.push_back(int'(result_i));
      if (phy_tx_done) begin
        done_cnt++;
        if (post < 0) begin
          post = 4;
          started_at_done = int'(phy_tx_started);
        end
      end
      if (post > 0) post--;
      prev_valid = result_iq_valid;
      prev_ready = result_iq_ready;
      prev_i = result_i;
      if (cyc >= 20000) begin
        timed_out = 1;
        post = 0;
      end
    end
    phy_tx_start = 1'b0;
  endtask

  task automatic compare_frame(input string tag);
    int bad, first_bad, n;
    check({tag, "/timeout"}, int'(timed_out), 0);
    check({tag, "/count"}, got.size(), expq.size());
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/started_at_done"}, started_at_done, 0);
    check({tag, "/started_at_first_valid"}, started_at_fv, 1);
    check({tag, "/latency_ok"}, int'(first_valid > 0 && first_valid <= 100), 1);
    check({tag, "/hold_violations"}, hold_bad, 0);
    check({tag, "/q_nonzero"}, q_nonzero, 0);
    bad = 0; first_bad = -1;
    n = got.size() < expq.size() ? got.size() : expq.size();
    for (int k = 0; k < n; k++)
      if (got[k] != expq[k]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    check({tag, "/sample_mismatches"}, bad, 0);
    if (bad != 0)
      $display("  first differing sample %0d: got %0d want %0d", first_bad,
               got[first_bad], expq[first_bad]);
  endtask

  initial begin
    int nz, diff, cyc;
    logic [127:0] m_all, m_b1;
    m_all = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    m_b1  = 128'h2;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst/valid", int'(result_iq_valid), 0);
    check("rst/started", int'(phy_tx_started), 0);
    check("rst/done", int'(phy_tx_done), 0);
    check("rst/addr", int'(bram_addr), 0);
    check("rst/i", int'(result_i), 0);
    reset = 1'b0;

    // Frame A: LEN=1, byte 0x00, seeds 7F, no mask
    fill(1, 1'b1);
    build_model(1, 7'h7F, 7'h7F, '0);
    run_frame(7'h7F, 7'h7F, '0, 1'b0, -1);
    compare_frame("A");
    check("A/n128", got.size(), 128);
    if (got.size() >= 128) begin
      check("A/pilot7", got[7], 8192);
      check("A/pilot21", got[21], -8192);
      check("A/pilot43", got[43], 8192);
      check("A/pilot57", got[57], 8192);
      nz = 0;
      for (int sy = 0; sy < 2; sy++)
        for (int b = 0; b < 64; b++)
          if ((b == 0 || (b >= 27 && b <= 37)) && got[64 * sy + b] != 0) nz++;
      check("A/null_bins", nz, 0);
    end
    refA = got;

    // Frame B: every bin masked
    build_model(1, 7'h7F, 7'h7F, m_all);
    run_frame(7'h7F, 7'h7F, m_all, 1'b0, -1);
    compare_frame("B");
    nz = 0;
    foreach (got[k]) if (got[k] != 0) nz++;
    check("B/all_zero", nz, 0);

    // Frame C: bin 1 masked, everything else as frame A
    build_model(1, 7'h7F, 7'h7F, m_b1);
    run_frame(7'h7F, 7'h7F, m_b1, 1'b0, -1);
    compare_frame("C");
    if (got.size() == 128 && refA.size() == 128) begin
      check("C/bin1_s0", got[1], 0);
      check("C/bin1_s1", got[65], 0);
      diff = 0;
      for (int k = 0; k < 128; k++)
        if (k != 1 && k != 65 && got[k] != refA[k]) diff++;
      check("C/others_vs_A", diff, 0);
    end

    // Frame D: LEN=100 random payload, random ready
    fill(100, 1'b0);
    build_model(100, 7'h5D, 7'h33, '0);
    run_frame(7'h5D, 7'h33, '0, 1'b1, -1);
    compare_frame("D");
    check("D/n2240", got.size(), 2240);

    // Reset mid-frame, then a full frame
    @(negedge clock);
    init_data_scram_state = 7'h5D;
    init_pilot_scram_state = 7'h33;
    mask = '0;
    result_iq_ready = 1'b1;
    phy_tx_start = 1'b1;
    @(negedge clock);
    phy_tx_start = 1'b0;
    cyc = 0;
    while (!result_iq_valid && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("E/valid_before_reset", int'(result_iq_valid), 1);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("E/valid_after_reset", int'(result_iq_valid), 0);
    check("E/started_after_reset", int'(phy_tx_started), 0);
    check("E/done_after_reset", int'(phy_tx_done), 0);
    reset = 1'b0;
    run_frame(7'h5D, 7'h33, '0, 1'b1, -1);
    compare_frame("E");

    // Start re-pulsed while RUN is streaming
    fill(1, 1'b1);
    build_model(1, 7'h7F, 7'h7F, '0);
    run_frame(7'h7F, 7'h7F, '0, 1'b0, 40);
    compare_frame("F");
    check("F/n128", got.size(), 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
